// File: rtl/psram_lcd_stream.sv
// RGB LCD timing generator fed from the PSRAM read FIFO: one pixel per clk, fixed
// two-clk latency from counters to pins, fill colour and sticky logging on underrun.
module psram_lcd_stream #(
    parameter int          H_ACTIVE   = 480,
    parameter int          H_FP       = 8,
    parameter int          H_SYNC     = 4,
    parameter int          H_BP       = 43,
    parameter int          V_ACTIVE   = 272,
    parameter int          V_FP       = 8,
    parameter int          V_SYNC     = 4,
    parameter int          V_BP       = 12,
    parameter logic [15:0] FILL_COLOR = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        clear_underrun,
    input  logic [16:0] rdfifo_q,
    input  logic        rdfifo_rdempty,
    output logic        rdfifo_rdreq,
    output logic        lcd_hsync,
    output logic        lcd_vsync,
    output logic        lcd_de,
    output logic [4:0]  lcd_r,
    output logic [5:0]  lcd_g,
    output logic [4:0]  lcd_b,
    output logic        frame_start,
    output logic        underrun,
    output logic [15:0] underrun_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_FIRST = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_FIRST = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Raster counters
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;

    // Stage 1: pop acknowledge and timing flags delayed by one clk
    logic pop_ok_q, pop_ok_d;
    logic de_s1_q, de_s1_d;
    logic hs_s1_q, hs_s1_d;
    logic vs_s1_q, vs_s1_d;
    logic fs_s1_q, fs_s1_d;

    // Stage 2: pin registers
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        de_q, de_d;
    logic        fs_q, fs_d;
    logic [15:0] rgb_q, rgb_d;

    // Underrun logging
    logic        underrun_q, underrun_d;
    logic [15:0] cnt_q, cnt_d;

    logic de_pre;
    logic hs_pre;
    logic vs_pre;
    logic frame_pre;
    logic underrun_evt;
    logic unused_flag_bit;

    assign de_pre    = (h_q < H_ACT_END) && (v_q < V_ACT_END);
    assign hs_pre    = (h_q >= H_SYNC_FIRST) && (h_q <= H_SYNC_LAST);
    assign vs_pre    = (v_q >= V_SYNC_FIRST) && (v_q <= V_SYNC_LAST);
    assign frame_pre = (h_q == '0) && (v_q == '0);

    // Pop is qualified with the live empty flag, so a pop can never land on an empty FIFO.
    assign rdfifo_rdreq    = enable && !reset && de_pre && !rdfifo_rdempty;
    assign underrun_evt    = enable && de_pre && rdfifo_rdempty;
    assign unused_flag_bit = rdfifo_q[16];

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        h_d = '0;
        v_d = '0;
        if (enable) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
                v_d = v_q;
            end
        end
    end

    always_comb begin
        pop_ok_d = rdfifo_rdreq;
        de_s1_d  = enable && de_pre;
        hs_s1_d  = enable && hs_pre;
        vs_s1_d  = enable && vs_pre;
        fs_s1_d  = enable && frame_pre;
    end

    // Disabling forces the pin stage idle at once, dropping any pixel already popped.
    always_comb begin
        hsync_d = !(enable && hs_s1_q);
        vsync_d = !(enable && vs_s1_q);
        de_d    = enable && de_s1_q;
        fs_d    = enable && fs_s1_q;
        rgb_d   = 16'h0000;
        if (enable) begin
            if (pop_ok_q) begin
                rgb_d = rdfifo_q[15:0];
            end else if (de_s1_q) begin
                rgb_d = FILL_COLOR;
            end
        end
    end

    // A fresh underrun on the clearing clk still counts, so it wins over the clear.
    always_comb begin
        underrun_d = underrun_q;
        cnt_d      = cnt_q;
        if (clear_underrun) begin
            underrun_d = 1'b0;
            cnt_d      = 16'h0000;
        end
        if (underrun_evt) begin
            underrun_d = 1'b1;
            if (clear_underrun) begin
                cnt_d = 16'h0001;
            end else if (cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'h0001;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking everywhere in clocked blocks so each register sees pre-edge values.
        if (reset) begin
            h_q        <= '0;
            v_q        <= '0;
            pop_ok_q   <= 1'b0;
            de_s1_q    <= 1'b0;
            hs_s1_q    <= 1'b0;
            vs_s1_q    <= 1'b0;
            fs_s1_q    <= 1'b0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            de_q       <= 1'b0;
            fs_q       <= 1'b0;
            rgb_q      <= 16'h0000;
            underrun_q <= 1'b0;
            cnt_q      <= 16'h0000;
        end else begin
            h_q        <= h_d;
            v_q        <= v_d;
            pop_ok_q   <= pop_ok_d;
            de_s1_q    <= de_s1_d;
            hs_s1_q    <= hs_s1_d;
            vs_s1_q    <= vs_s1_d;
            fs_s1_q    <= fs_s1_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            de_q       <= de_d;
            fs_q       <= fs_d;
            rgb_q      <= rgb_d;
            underrun_q <= underrun_d;
            cnt_q      <= cnt_d;
        end
    end

    assign lcd_hsync    = hsync_q;
    assign lcd_vsync    = vsync_q;
    assign lcd_de       = de_q;
    assign lcd_r        = rgb_q[15:11];
    assign lcd_g        = rgb_q[10:5];
    assign lcd_b        = rgb_q[4:0];
    assign frame_start  = fs_q;
    assign underrun     = underrun_q;
    assign underrun_cnt = cnt_q;

endmodule

// File: tb/tb_psram_lcd_stream.sv
// Bench for psram_lcd_stream: small-raster timing table, data path, underrun,
// clear/saturation, reset and enable corner cases against a FIFO model.
module tb_psram_lcd_stream;

    localparam logic [15:0] FILL = 16'h1234;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        clear_underrun = 1'b0;
    logic [16:0] fifo_q = '0;
    logic        rdfifo_rdempty;
    logic        rdfifo_rdreq;
    logic        lcd_hsync, lcd_vsync, lcd_de, frame_start, underrun;
    logic [4:0]  lcd_r, lcd_b;
    logic [5:0]  lcd_g;
    logic [15:0] underrun_cnt;
    logic [15:0] rgb;
    assign rgb = {lcd_r, lcd_g, lcd_b};

    psram_lcd_stream #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .FILL_COLOR(FILL)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .clear_underrun(clear_underrun),
        .rdfifo_q(fifo_q), .rdfifo_rdempty(rdfifo_rdempty), .rdfifo_rdreq(rdfifo_rdreq),
        .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync), .lcd_de(lcd_de),
        .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b),
        .frame_start(frame_start), .underrun(underrun), .underrun_cnt(underrun_cnt)
    );

    // Wide-line instance, permanently starved, used to reach counter saturation.
    logic        reset2 = 1'b1;
    logic        enable2 = 1'b0;
    logic        clear2 = 1'b0;
    logic        rdreq2, underrun2;
    logic [15:0] cnt2;
    logic        u2_unused_hs, u2_unused_vs, u2_unused_de, u2_unused_fs;
    logic [4:0]  u2_unused_r, u2_unused_b;
    logic [5:0]  u2_unused_g;

    psram_lcd_stream #(
        .H_ACTIVE(16384), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut2 (
        .clk(clk), .reset(reset2), .enable(enable2), .clear_underrun(clear2),
        .rdfifo_q(17'h0), .rdfifo_rdempty(1'b1), .rdfifo_rdreq(rdreq2),
        .lcd_hsync(u2_unused_hs), .lcd_vsync(u2_unused_vs), .lcd_de(u2_unused_de),
        .lcd_r(u2_unused_r), .lcd_g(u2_unused_g), .lcd_b(u2_unused_b),
        .frame_start(u2_unused_fs), .underrun(underrun2), .underrun_cnt(cnt2)
    );

    // FIFO model: normal-mode read, data valid the clk after the pop.
    logic [16:0] fifo_mem [0:255];
    int fifo_wr = 0;
    int fifo_rd = 0;
    int pops = 0;
    int viol = 0;
    int pops_base = 0;
    assign rdfifo_rdempty = (fifo_rd == fifo_wr);

    always @(posedge clk) begin
        if (rdfifo_rdreq) begin
            if (fifo_rd == fifo_wr) begin
                viol <= viol + 1;
            end else begin
                fifo_q  <= fifo_mem[fifo_rd];
                fifo_rd <= fifo_rd + 1;
                pops    <= pops + 1;
            end
        end
    end

    int n_vec = 0;
    int n_miss = 0;
    int cur = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_to(input int n);
        while (cur < n) begin
            tick();
            cur++;
        end
    endtask

    task automatic push(input logic [16:0] w);
        fifo_mem[fifo_wr] = w;
        fifo_wr++;
    endtask

    task automatic restart();
        reset = 1'b1;
        enable = 1'b0;
        clear_underrun = 1'b0;
        tick();
        fifo_wr = fifo_rd;
        pops_base = pops;
    endtask

    task automatic go();
        reset = 1'b0;
        enable = 1'b1;
        cur = 0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".de"}, 32'(lcd_de), 32'd0);
        check({tag, ".hsync"}, 32'(lcd_hsync), 32'd1);
        check({tag, ".vsync"}, 32'(lcd_vsync), 32'd1);
        check({tag, ".fs"}, 32'(frame_start), 32'd0);
        check({tag, ".rgb"}, 32'(rgb), 32'd0);
    endtask

    typedef struct {
        int          cyc;
        logic        de;
        logic        hs;
        logic        vs;
        logic        fs;
        logic [15:0] rgb;
    } vec_t;

    vec_t vecs[$];
    int exp_r[4] = '{31, 0, 0, 31};
    int exp_g[4] = '{0, 63, 0, 63};
    int exp_b[4] = '{0, 0, 31, 31};

    initial begin
        // Edge n after enable shows raster position p = n-2 (h = p%7, v = (p/7)%5).
        vecs.push_back('{1,  1'b0, 1'b1, 1'b1, 1'b0, 16'h0000});
        vecs.push_back('{2,  1'b1, 1'b1, 1'b1, 1'b1, 16'hA000});
        vecs.push_back('{3,  1'b1, 1'b1, 1'b1, 1'b0, 16'hA001});
        vecs.push_back('{5,  1'b1, 1'b1, 1'b1, 1'b0, 16'hA003});
        vecs.push_back('{6,  1'b0, 1'b1, 1'b1, 1'b0, 16'h0000});
        vecs.push_back('{7,  1'b0, 1'b0, 1'b1, 1'b0, 16'h0000});
        vecs.push_back('{8,  1'b0, 1'b1, 1'b1, 1'b0, 16'h0000});
        vecs.push_back('{9,  1'b1, 1'b1, 1'b1, 1'b0, 16'hA004});
        vecs.push_back('{12, 1'b1, 1'b1, 1'b1, 1'b0, 16'hA007});
        vecs.push_back('{16, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000});
        vecs.push_back('{21, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000});
        vecs.push_back('{23, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000});
        vecs.push_back('{28, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000});
        vecs.push_back('{29, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000});
        vecs.push_back('{30, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000});
        vecs.push_back('{36, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000});
        vecs.push_back('{37, 1'b1, 1'b1, 1'b1, 1'b1, 16'hA008});
        vecs.push_back('{38, 1'b1, 1'b1, 1'b1, 1'b0, 16'hA009});

        // Reset state
        tick();
        tick();
        check("rst.rdreq", 32'(rdfifo_rdreq), 32'd0);
        check_idle("rst");
        check("rst.underrun", 32'(underrun), 32'd0);
        check("rst.cnt", 32'(underrun_cnt), 32'd0);

        // Frame timing with a FIFO that never runs dry; bit 16 set to show it is ignored
        restart();
        for (int i = 0; i < 64; i++) push({1'b1, 16'hA000 + 16'(i)});
        go();
        foreach (vecs[i]) begin
            run_to(vecs[i].cyc);
            check($sformatf("t1.v%0d.de", i), 32'(lcd_de), 32'(vecs[i].de));
            check($sformatf("t1.v%0d.hsync", i), 32'(lcd_hsync), 32'(vecs[i].hs));
            check($sformatf("t1.v%0d.vsync", i), 32'(lcd_vsync), 32'(vecs[i].vs));
            check($sformatf("t1.v%0d.fs", i), 32'(frame_start), 32'(vecs[i].fs));
            check($sformatf("t1.v%0d.rgb", i), 32'(rgb), 32'(vecs[i].rgb));
        end
        check("t1.pops", 32'(pops - pops_base), 32'd11);
        check("t1.underrun", 32'(underrun), 32'd0);

        // Data path: primary colours and white
        restart();
        push(17'h0F800);
        push(17'h007E0);
        push(17'h0001F);
        push(17'h0FFFF);
        go();
        for (int k = 0; k < 4; k++) begin
            run_to(k + 2);
            check($sformatf("t2.px%0d.r", k), 32'(lcd_r), 32'(exp_r[k]));
            check($sformatf("t2.px%0d.g", k), 32'(lcd_g), 32'(exp_g[k]));
            check($sformatf("t2.px%0d.b", k), 32'(lcd_b), 32'(exp_b[k]));
        end
        run_to(9);
        check("t2.line1_fill", 32'(rgb), 32'(FILL));
        run_to(20);
        check("t2.pops", 32'(pops - pops_base), 32'd4);

        // Underrun after two words
        restart();
        push(17'h01111);
        push(17'h02222);
        go();
        run_to(2);
        check("t3.px0", 32'(rgb), 32'h1111);
        check("t3.cnt_early", 32'(underrun_cnt), 32'd0);
        run_to(3);
        check("t3.px1", 32'(rgb), 32'h2222);
        run_to(4);
        check("t3.px2", 32'(rgb), 32'(FILL));
        check("t3.px2.de", 32'(lcd_de), 32'd1);
        run_to(5);
        check("t3.px3", 32'(rgb), 32'(FILL));
        run_to(7);
        check("t3.underrun", 32'(underrun), 32'd1);
        check("t3.cnt", 32'(underrun_cnt), 32'd2);
        check("t3.pops", 32'(pops - pops_base), 32'd2);

        // Clear on the same clk as an underrun, then a plain clear in the porch
        clear_underrun = 1'b1;
        run_to(8);
        clear_underrun = 1'b0;
        check("t4.sameclk.cnt", 32'(underrun_cnt), 32'd1);
        check("t4.sameclk.flag", 32'(underrun), 32'd1);
        run_to(11);
        check("t4.cnt4", 32'(underrun_cnt), 32'd4);
        clear_underrun = 1'b1;
        run_to(12);
        clear_underrun = 1'b0;
        check("t4.clr.cnt", 32'(underrun_cnt), 32'd0);
        check("t4.clr.flag", 32'(underrun), 32'd0);

        // Reset at h=2, v=1, then enable drop and re-enable
        restart();
        for (int i = 0; i < 32; i++) push({1'b0, 16'h5000 + 16'(i)});
        go();
        run_to(9);
        reset = 1'b1;
        #1;
        check("t5.rst.rdreq_now", 32'(rdfifo_rdreq), 32'd0);
        run_to(10);
        check_idle("t5.rst");
        check("t5.rst.rdreq", 32'(rdfifo_rdreq), 32'd0);
        check("t5.rst.cnt", 32'(underrun_cnt), 32'd0);
        reset = 1'b0;
        run_to(12);
        check("t5.restart.fs", 32'(frame_start), 32'd1);
        check("t5.restart.de", 32'(lcd_de), 32'd1);
        check("t5.restart.rgb", 32'(rgb), 32'h5006);
        run_to(13);
        check("t5.px1.rgb", 32'(rgb), 32'h5007);
        enable = 1'b0;
        #1;
        check("t5.dis.rdreq", 32'(rdfifo_rdreq), 32'd0);
        run_to(15);
        check_idle("t5.dis");
        check("t5.dis.pops", 32'(pops - pops_base), 32'd9);
        enable = 1'b1;
        run_to(17);
        check("t5.reen.fs", 32'(frame_start), 32'd1);
        check("t5.reen.rgb", 32'(rgb), 32'h5009);

        check("fifo.empty_pops", 32'(viol), 32'd0);

        // Saturation on the wide instance: 65536 starved pixels in lines 0-3
        reset2 = 1'b0;
        enable2 = 1'b1;
        repeat (65543) tick();
        check("t4.sat.cnt_fffe", 32'(cnt2), 32'hFFFE);
        check("t4.sat.flag", 32'(underrun2), 32'd1);
        repeat (17) tick();
        check("t4.sat.cnt_ffff", 32'(cnt2), 32'hFFFF);
        check("t4.sat.rdreq", 32'(rdreq2), 32'd0);
        clear2 = 1'b1;
        tick();
        clear2 = 1'b0;
        check("t4.sat.clr.cnt", 32'(cnt2), 32'd0);
        check("t4.sat.clr.flag", 32'(underrun2), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
